inst_fetch_unit: RTL and testbench

//  Producer end of the 32-bit instruction interface consumed by the control decoder.
//  - Holds the PC and fetches from instruction memory over a req/ack handshake.
//  - Presents each instruction with a valid/ready handshake.
//  - Applies the decoder's PCSel redirect, using the ALU result as the target.
//  - Sits between IMEM and the decode/control stage of the RV32I core.

---
 rtl/rv32i_pkg.sv | 27 ++
 rtl/ifu_watchdog.sv | 30 +++
 rtl/inst_fetch_unit.sv | 113 +++++++++++
 tb/tb_inst_fetch_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: widths, NOP encoding, reset PC, opcodes and IFU state encoding.
// Used by the fetch unit and the control decoder.
package rv32i_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/ifu_watchdog.sv
// Purpose: counts consecutive REQ cycles without ack and flags expiry. Present only with IFU_TIMEOUT_EN.
// Latency: expired is combinational on the TIMEOUT_CYCLES-th waiting cycle; backpressure: none.
`ifdef IFU_TIMEOUT_EN
module ifu_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Any non-waiting cycle clears the count, so every entry into REQ starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (waiting) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    assign expired = waiting && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/inst_fetch_unit.sv
// Purpose: holds the PC, fetches from IMEM over req/ack, presents inst/pc to decode; optional IFU_TIMEOUT_EN watchdog.
// Latency: 1 cycle from ack to inst_valid; 1 instruction per 2 cycles at best.
// Backpressure: inst/pc held stable while inst_valid & !inst_ready; no new request until accept.
module inst_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic            PCSel,
    input  logic [XLEN-1:0] ALU_result,
    output logic            fetch_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    ifu_state_t      state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] inst_q, inst_nxt;
    logic            err_q, err_nxt;
    logic [XLEN-1:0] next_pc;
    logic            wd_expired;

`ifdef IFU_TIMEOUT_EN
    ifu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .waiting((state == REQ) && !imem_ack),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BOOT;
            pc_q   <= RESET_PC;
            inst_q <= NOP_INST;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_nxt;
            inst_q <= inst_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        inst_nxt  = inst_q;
        err_nxt   = err_q;
        // Redirect target has bit 0 forced low; bit 1 set means a misaligned word address.
        next_pc   = PCSel ? (ALU_result & ~32'd1) : (pc_q + 32'd4);

        case (state)
            BOOT: begin
                state_nxt = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    inst_nxt  = imem_rdata;
                    state_nxt = VALID;
                end else if (wd_expired) begin
                    inst_nxt  = NOP_INST;
                    err_nxt   = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (inst_ready) begin
                    if (next_pc[1]) begin
                        err_nxt   = 1'b1;
                        state_nxt = ERR;
                    end else begin
                        pc_nxt    = next_pc;
                        state_nxt = REQ;
                    end
                end
            end
            ERR: begin
                err_nxt = 1'b1;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Request and valid decode straight from state so an async reset drops them immediately.
    assign imem_req   = (state == REQ);
    assign imem_addr  = pc_q;
    assign inst_valid = (state == VALID);
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed table of per-cycle vectors for the fetch unit, followed by reset and timeout sequences.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I1  = 32'h0010_8113;
    localparam logic [31:0] I2  = 32'h0020_81b3;
    localparam logic [31:0] I3  = 32'h0000_0263;
    localparam logic [31:0] I4  = 32'h0040_02ef;
    localparam logic [31:0] I5  = 32'h0000_8067;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        PCSel = 1'b0;
    logic [31:0] ALU_result = '0;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;

    inst_fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .inst      (inst),
        .pc        (pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .PCSel     (PCSel),
        .ALU_result(ALU_result),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        sel;
        logic [31:0] alu;
        logic        req;
        logic        valid;
        logic        err;
        logic [31:0] inst;
        logic [31:0] pc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic ack, logic [31:0] rdata, logic ready, logic sel,
                                logic [31:0] alu, logic req, logic valid, logic err,
                                logic [31:0] ins, logic [31:0] p);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.ready = ready; v.sel = sel; v.alu = alu;
        v.req = req; v.valid = valid; v.err = err; v.inst = ins; v.pc = p;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;

        //       ack rdata ready sel alu            req val err inst pc
        vq.push_back(mk(0, 0,   0, 0, 0,             0, 0, 0, NOP, 32'h0));
        vq.push_back(mk(1, I0,  0, 0, 0,             1, 0, 0, NOP, 32'h0));
        vq.push_back(mk(0, 0,   1, 0, 0,             0, 1, 0, I0,  32'h0));
        vq.push_back(mk(1, I1,  0, 0, 0,             1, 0, 0, I0,  32'h4));
        vq.push_back(mk(0, 0,   1, 0, 0,             0, 1, 0, I1,  32'h4));
        vq.push_back(mk(0, 0,   0, 0, 0,             1, 0, 0, I1,  32'h8));
        vq.push_back(mk(0, 0,   0, 0, 0,             1, 0, 0, I1,  32'h8));
        vq.push_back(mk(0, 0,   0, 0, 0,             1, 0, 0, I1,  32'h8));
        vq.push_back(mk(1, I2,  0, 0, 0,             1, 0, 0, I1,  32'h8));
        vq.push_back(mk(1, BAD, 0, 1, 32'h102,       0, 1, 0, I2,  32'h8));
        vq.push_back(mk(0, 0,   0, 0, 0,             0, 1, 0, I2,  32'h8));
        vq.push_back(mk(0, 0,   1, 1, 32'h101,       0, 1, 0, I2,  32'h8));
        vq.push_back(mk(1, I3,  0, 0, 0,             1, 0, 0, I2,  32'h100));
        vq.push_back(mk(0, 0,   1, 1, 32'hFFFF_FFFC, 0, 1, 0, I3,  32'h100));
        vq.push_back(mk(1, I4,  0, 0, 0,             1, 0, 0, I3,  32'hFFFF_FFFC));
        vq.push_back(mk(0, 0,   1, 0, 32'h102,       0, 1, 0, I4,  32'hFFFF_FFFC));
        vq.push_back(mk(1, I5,  0, 0, 0,             1, 0, 0, I4,  32'h0));
        vq.push_back(mk(0, 0,   1, 1, 32'h102,       0, 1, 0, I5,  32'h0));
        vq.push_back(mk(1, BAD, 1, 0, 0,             0, 0, 1, I5,  32'h0));
        vq.push_back(mk(1, BAD, 1, 0, 0,             0, 0, 1, I5,  32'h0));

        repeat (2) @(negedge clk);
        check("rst_req",   {31'd0, imem_req},   32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_err",   {31'd0, fetch_err},  32'd0);
        check("rst_pc",    pc,                  32'h0);
        check("rst_inst",  inst,                NOP);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            imem_ack   = vq[i].ack;
            imem_rdata = vq[i].rdata;
            inst_ready = vq[i].ready;
            PCSel      = vq[i].sel;
            ALU_result = vq[i].alu;
            #1;
            check($sformatf("v%0d_req", i),   {31'd0, imem_req},   {31'd0, vq[i].req});
            check($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vq[i].valid});
            check($sformatf("v%0d_err", i),   {31'd0, fetch_err},  {31'd0, vq[i].err});
            check($sformatf("v%0d_inst", i),  inst,                 vq[i].inst);
            check($sformatf("v%0d_pc", i),    pc,                   vq[i].pc);
            check($sformatf("v%0d_addr", i),  imem_addr,            vq[i].pc);
            step();
        end

        // Still parked in ERR: a reset pulse clears the error and fetch restarts at RESET_PC.
        inst_ready = 1'b0;
        check("err_hold", {30'd0, fetch_err, imem_req}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("errrst_err",  {31'd0, fetch_err}, 32'd0);
        check("errrst_inst", inst,               NOP);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("late_ack_boot_req",  {31'd0, imem_req}, 32'd0);
        check("late_ack_boot_inst", inst,              NOP);
        step();
        imem_ack = 1'b0;
        #1;
        check("restart_req",  {31'd0, imem_req}, 32'd1);
        check("restart_addr", imem_addr,         32'h0);
        check("restart_inst", inst,              NOP);

        // Reset asserted while a request is outstanding drops imem_req at once.
        #2 rst_n = 1'b0;
        #1;
        check("midreq_rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        n = 0;
        while (n < 100 && !inst_valid) begin
            if (imem_req) n++;
            step();
        end
`ifdef IFU_TIMEOUT_EN
        check("timeout_cycles", n,                   32'd16);
        check("timeout_valid",  {31'd0, inst_valid}, 32'd1);
        check("timeout_inst",   inst,                NOP);
        check("timeout_err",    {31'd0, fetch_err},  32'd1);
`else
        check("noto_cycles", n,                   32'd100);
        check("noto_req",    {31'd0, imem_req},   32'd1);
        check("noto_valid",  {31'd0, inst_valid}, 32'd0);
        check("noto_err",    {31'd0, fetch_err},  32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
